// File: rtl/sram_mem_controller.sv
// MEM-stage load/store initiator for an external 16-bit asynchronous SRAM.
// Each 32-bit word is moved as two half-accesses (low half, then high half).
module sram_mem_controller #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_en,
    input  logic              write_en,
    input  logic [15:0]       address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              ready,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int              CNT_W = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              is_write;
    logic [15:0]       dq_out;
    logic              dq_oe;
    logic              req;
    logic [15:0]       word;
    logic [ADDR_W-2:0] word_a;

    assign req    = read_en | write_en;
    assign word   = (address - 16'd1024) >> 2;
    assign word_a = (ADDR_W-1)'(word);

    // Handshake: the pipeline holds read_en/write_en/address/writedata stable while
    // ready is low; ready rises only in DONE, and the pipeline advances at the end of that cycle.
    assign ready     = ~req | (state == DONE);
    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            is_write  <= 1'b0;
            readdata  <= '0;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state     <= LO;
                        cnt       <= '0;
                        is_write  <= write_en;
                        SRAM_ADDR <= {word_a, 1'b0};
                        SRAM_CE_N <= 1'b0;
                        SRAM_UB_N <= 1'b0;
                        SRAM_LB_N <= 1'b0;
                        SRAM_OE_N <= write_en;
                        SRAM_WE_N <= ~write_en;
                        dq_out    <= writedata[15:0];
                        dq_oe     <= write_en;
                    end
                end
                LO: begin
                    if (cnt == LAST) begin
                        if (!is_write) readdata[15:0] <= SRAM_DQ;
                        state     <= HI;
                        cnt       <= '0;
                        SRAM_ADDR <= {word_a, 1'b1};
                        SRAM_WE_N <= ~is_write;
                        dq_out    <= writedata[31:16];
                    end else begin
                        cnt       <= cnt + 1'b1;
                        // WE_N rises one cycle before the phase ends so address/data outlast it
                        SRAM_WE_N <= ~is_write | (cnt + 1'b1 == LAST);
                    end
                end
                HI: begin
                    if (cnt == LAST) begin
                        if (!is_write) readdata[31:16] <= SRAM_DQ;
                        state     <= DONE;
                        cnt       <= '0;
                        SRAM_ADDR <= '0;
                        SRAM_CE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        SRAM_WE_N <= 1'b1;
                        SRAM_UB_N <= 1'b1;
                        SRAM_LB_N <= 1'b1;
                        dq_oe     <= 1'b0;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        SRAM_WE_N <= ~is_write | (cnt + 1'b1 == LAST);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: async SRAM model, word-level reference memory,
// directed cases followed by randomized load/store traffic.
module tb_sram_mem_controller;

    localparam int ADDR_W = 18;
    localparam int W      = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              read_en;
    logic              write_en;
    logic [15:0]       address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              ready;
    logic [ADDR_W-1:0] sram_addr;
    wire  [15:0]       sram_dq;
    logic              ce_n, oe_n, we_n, ub_n, lb_n;
    logic [1:0]        dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] sram_mem [0:(1<<ADDR_W)-1];
    logic [15:0] ref_mem [int];
    logic [31:0] exp_q [$];
    logic [31:0] exp_rd;

    sram_mem_controller #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .read_en   (read_en),
        .write_en  (write_en),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .ready     (ready),
        .SRAM_ADDR (sram_addr),
        .SRAM_DQ   (sram_dq),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .SRAM_WE_N (we_n),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // asynchronous SRAM: drives the bus on reads, latches on the WE_N rising edge
    assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr] : 16'hzzzz;

    always @(posedge we_n) begin
        if (!ce_n) sram_mem[sram_addr] = sram_dq;
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) sram_mem[i] = 16'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    // SRAM halfword index of the low half: (byte offset from 1024) / 4 words, 2 halves each
    function automatic int lo_addr(input logic [15:0] a);
        logic [15:0] off;
        off = a - 16'd1024;
        return int'(off / 16'd4) * 2;
    endfunction

    // driver: new request appears just after the edge that ends the previous cycle
    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        read_en   = rd;
        write_en  = wr;
        address   = a;
        writedata = wd;
    endtask

    // checks one full transaction starting in its request cycle (cycle 0)
    task automatic check_txn(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] wd);
        logic is_w;
        int   lo;
        is_w = wr;
        lo   = lo_addr(a);
        if (is_w) begin
            ref_mem[lo]     = wd[15:0];
            ref_mem[lo + 1] = wd[31:16];
        end else if (rd) begin
            exp_q.push_back({ref_rd(lo + 1), ref_rd(lo)});
        end
        for (int k = 0; k <= 2 * W + 1; k++) begin
            logic in_lo, in_hi, in_ph;
            int   c;
            int   ea;
            if (k > 0) @(posedge clk);
            #1;
            in_lo = (k >= 1) && (k <= W);
            in_hi = (k > W) && (k <= 2 * W);
            in_ph = in_lo || in_hi;
            c     = (k - 1) % W;
            ea    = in_lo ? lo : (in_hi ? lo + 1 : 0);
            chk($sformatf("ready k=%0d a=%h", k, a), 32'(ready), 32'(k == 2 * W + 1));
            chk($sformatf("ctl k=%0d a=%h", k, a), 32'({ce_n, oe_n, we_n}),
                32'({!in_ph, !(in_ph && !is_w), !(in_ph && is_w && c != W - 1)}));
            chk($sformatf("addr k=%0d a=%h", k, a), 32'(sram_addr), 32'(ea));
            if (in_ph) chk($sformatf("ublb k=%0d", k), 32'({ub_n, lb_n}), 32'h0);
            if (in_ph && is_w)
                chk($sformatf("dq k=%0d", k), 32'(sram_dq), 32'(in_lo ? wd[15:0] : wd[31:16]));
        end
        if (!is_w && rd) exp_rd = exp_q.pop_front();
        chk($sformatf("readdata a=%h", a), readdata, exp_rd);
        if (is_w) begin
            chk($sformatf("mem_lo a=%h", a), 32'(sram_mem[lo]), 32'(wd[15:0]));
            chk($sformatf("mem_hi a=%h", a), 32'(sram_mem[lo + 1]), 32'(wd[31:16]));
        end
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] wd);
        drive(rd, wr, a, wd);
        check_txn(rd, wr, a, wd);
    endtask

    initial begin
        logic        rd, wr;
        logic [15:0] a;
        logic [31:0] wd;
        int          kind;

        rst = 1'b0; read_en = 1'b0; write_en = 1'b0; address = '0; writedata = '0;
        exp_rd = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'h1);
        chk("rst_ctl", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1f);
        chk("rst_readdata", readdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle_ready %0d", i), 32'(ready), 32'h1);
            chk($sformatf("idle_ctl %0d", i), 32'({ce_n, oe_n, we_n}), 32'h7);
            chk($sformatf("idle_addr %0d", i), 32'(sram_addr), 32'h0);
        end

        // directed cases
        txn(1'b0, 1'b1, 16'd1024, 32'h1234_5678);
        txn(1'b1, 1'b0, 16'd1024, 32'h0);
        txn(1'b0, 1'b1, 16'd1028, 32'hDEAD_BEEF);
        txn(1'b1, 1'b0, 16'd1028, 32'h0);

        // reset in HI cycle 1 of a read, request held through release
        drive(1'b1, 1'b0, 16'd1024, 32'h0);
        for (int k = 1; k <= W + 2; k++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_rd_lo_half", 32'(readdata[15:0]), 32'h5678);
        rst = 1'b0;
        #1;
        chk("arst_readdata", readdata, 32'h0);
        chk("arst_ctl", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1f);
        chk("arst_ready", 32'(ready), 32'h0);
        chk("arst_addr", 32'(sram_addr), 32'h0);
        exp_rd = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_txn(1'b1, 1'b0, 16'd1024, 32'h0);

        // both enables: treated as a write, readdata untouched
        txn(1'b1, 1'b1, 16'd1032, 32'hA5A5_0F0F);
        txn(1'b1, 1'b0, 16'd1032, 32'h0);

        // randomized traffic, including wrapped addresses
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 2);
            rd   = (kind != 1);
            wr   = (kind != 0);
            if ($urandom_range(0, 4) == 0) a = 16'($urandom);
            else a = 16'(1024 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3));
            wd = $urandom;
            txn(rd, wr, a, wd);
        end

        drive(1'b0, 1'b0, 16'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("tail_ready %0d", i), 32'(ready), 32'h1);
            chk($sformatf("tail_ctl %0d", i), 32'({ce_n, oe_n, we_n}), 32'h7);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- MEM-stage initiator that converts one-cycle pipeline load/store requests into multi-cycle transactions on an external 16-bit asynchronous SRAM.
- Replaces the on-chip register-array data memory.
- Splits each 32-bit word into two 16-bit half-accesses and drives a ready signal that the pipeline uses to freeze all stages until the access completes.

Parameters:
- ADDR_W, 18, SRAM halfword address width.
- WAIT_CYCLES, 3, cycles per half-access; legal range >= 2.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active-low.
- read_en  in  1  load request from MEM stage.
- write_en  in  1  store request from MEM stage.
- address  in  16  byte address from ALU.
- writedata  in  32  store data.
- readdata  out  32  load data, registered.
- ready  out  1  low = freeze pipeline; combinational.
- SRAM_ADDR  out  ADDR_W  halfword address.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_CE_N  out  1  chip enable, active-low.
- SRAM_OE_N  out  1  output enable, active-low.
- SRAM_WE_N  out  1  write enable, active-low.
- SRAM_UB_N  out  1  upper byte enable, active-low.
- SRAM_LB_N  out  1  lower byte enable, active-low.

Behaviour:
- Address map:
  - word = (address - 16'd1024) >> 2, modulo 2^16.
  - Low half at SRAM_ADDR = {word[ADDR_W-2:0], 1'b0}; high half at {word[ADDR_W-2:0], 1'b1}.
  - address[1:0] ignored. No range check; out-of-range addresses wrap.
- FSM states IDLE, LO, HI, DONE, with phase counter cnt (0..WAIT_CYCLES-1):
  - IDLE: if read_en|write_en then go to LO with cnt=0.
  - LO: cnt increments each cycle; at cnt==WAIT_CYCLES-1 go to HI with cnt=0.
  - HI: same counting; at cnt==WAIT_CYCLES-1 go to DONE.
  - DONE: always go to IDLE.
- Operation type is latched on leaving IDLE. If read_en and write_en are both high, the access is a write and readdata is unchanged.
- ready = ~(read_en|write_en) | (state==DONE).
- Latency: request present in IDLE at cycle 0 gives ready low for cycles 0..2*WAIT_CYCLES, and ready high in cycle 2*WAIT_CYCLES+1 (DONE).
  - The pipeline advances at the end of DONE.
  - A new request seen in IDLE the next cycle drops ready immediately.
  - No request ever needs a bubble between transactions.
- SRAM pins:
  - In IDLE/DONE: CE_N=OE_N=WE_N=1, DQ high-Z, SRAM_ADDR=0.
  - In LO/HI: CE_N=0, UB_N=LB_N=0, SRAM_ADDR per phase, held constant for the whole phase.
  - Write: DQ = writedata[15:0] in LO, writedata[31:16] in HI, driven for the whole phase. WE_N=0 for cnt 0..WAIT_CYCLES-2 and 1 at cnt==WAIT_CYCLES-1, giving address/data hold past the WE_N rising edge. OE_N=1.
  - Read: OE_N=0 for the whole phase, WE_N=1, DQ high-Z. readdata[15:0] captured from SRAM_DQ on the clock edge leaving LO at its last cycle; readdata[31:16] captured on the edge leaving HI.
- readdata holds its value until the next read overwrites it. The low half is updated at mid-transaction, so readdata is only valid in DONE and after.
- The pipeline must hold read_en, write_en, address and writedata stable while ready is low. The controller relatches only the operation type.
- Reset (rst low, asynchronous, any state including mid-phase):
  - state=IDLE, cnt=0, readdata=0.
  - CE_N=OE_N=WE_N=UB_N=LB_N=1, DQ high-Z.
  - ready follows its combinational formula.
  - An interrupted write may leave SRAM partially written; this is not repaired.
- Release of rst with a request asserted starts the transaction on the first clock edge after release.

Test Plan:
- No request, WAIT_CYCLES=3 -> ready=1 continuously; CE_N=OE_N=WE_N=1; DQ high-Z; readdata=0 after reset.
- Write address=1024, writedata=0x12345678 -> ready low 7 cycles, high cycle 8. SRAM model shows addr 0=0x5678, addr 1=0x1234. WE_N low exactly 2 cycles per phase, high in cycle 3 with address stable.
- Read address=1024 after the previous write -> readdata=0x12345678 in DONE; ready timing identical; DQ never driven by the controller.
- Back-to-back: write 0xDEADBEEF to 1028, then read 1028 in the next instruction -> SRAM addrs 2/3 = 0xBEEF/0xDEAD. ready low again the cycle after DONE with no idle gap; readdata=0xDEADBEEF.
- Reset asserted in HI cycle 1 of a read -> state IDLE, readdata=0 and all SRAM controls 1 asynchronously. After release with the request held, the full 7-cycle transaction restarts.
- read_en=write_en=1, address=1032, writedata=0xA5A5_0F0F -> performed as a write to addrs 4/5; readdata unchanged from its prior value.
